// File: rtl/sw_cfg_pkg.sv
// ----------------------------------------------------------------------------
// sw_cfg_pkg : shared types and helpers for the switch-side config responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sw_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_ACK  = 2'd2,
    ST_RD_ACK  = 2'd3
  } state_t;

  localparam int ACK_DATA_IDLE = 0;
  localparam int DELAY_W       = 4;

  function automatic int cfg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_cfg_regfile.sv
// ----------------------------------------------------------------------------
// sw_cfg_regfile : configuration registers, one write port, comb read, flat bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sw_cfg_regfile
  import sw_cfg_pkg::*;
#(
  parameter int                   W_WIDTH   = 8,
  parameter int                   NUM_REGS  = 8,
  parameter logic [W_WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [W_WIDTH-1:0]            waddr,
  input  logic [W_WIDTH-1:0]            wdata,
  input  logic [W_WIDTH-1:0]            raddr,
  output logic [W_WIDTH-1:0]            rdata,
  output logic [NUM_REGS*W_WIDTH-1:0]   cfg_out
);

  localparam int AW = W_WIDTH + 1;

  logic [W_WIDTH-1:0] regs [NUM_REGS];

  // Full-width equality per register: addresses >= NUM_REGS match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ({1'b0, waddr} == AW'(i)) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, raddr} == AW'(i)) rdata = regs[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_out[cfg_lsb(g, W_WIDTH) +: W_WIDTH] = regs[g];
  end

endmodule

`default_nettype wire

// File: rtl/sw_cfg_responder.sv
// ----------------------------------------------------------------------------
// sw_cfg_responder : switch end of the decoder link, one outstanding transaction
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sw_cfg_responder
  import sw_cfg_pkg::*;
#(
  parameter int                   READ_DELAY = 1,
  parameter int                   W_WIDTH    = 8,
  parameter int                   NUM_REGS   = 8,
  parameter logic [W_WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel_en,
  input  logic                          wr_rd_s,
  input  logic [W_WIDTH-1:0]            addr,
  input  logic [W_WIDTH-1:0]            wr_data,
  output logic                          ack,
  output logic [W_WIDTH-1:0]            rd_data,
  output logic                          busy,
  output logic [NUM_REGS*W_WIDTH-1:0]   cfg_out,
  output logic                          proto_err
);

  state_t               state, state_nx;
  logic [DELAY_W-1:0]   cnt, cnt_nx;
  logic [W_WIDTH-1:0]   cap_addr;
  logic [W_WIDTH-1:0]   cap_data;
  logic [W_WIDTH-1:0]   cap_rd;
  logic [W_WIDTH-1:0]   rf_rdata;
  logic                 accept;
  logic                 rf_we;

  assign accept = sel_en && (state == ST_IDLE);
  assign rf_we  = (state == ST_WR_ACK);

  sw_cfg_regfile #(
    .W_WIDTH   (W_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (cap_addr),
    .wdata   (cap_data),
    .raddr   (addr),
    .rdata   (rf_rdata),
    .cfg_out (cfg_out)
  );

  // Read data is snapshotted at accept so a long READ_DELAY returns accept-time contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_rd    <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_addr <= addr;
        cap_data <= wr_data;
        cap_rd   <= rf_rdata;
      end
      if (sel_en && (state != ST_IDLE)) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack      = 1'b0;
    rd_data  = W_WIDTH'(ACK_DATA_IDLE);
    busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (sel_en) begin
          if (wr_rd_s) begin
            state_nx = ST_WR_ACK;
          end else if (READ_DELAY == 0) begin
            state_nx = ST_RD_ACK;
          end else begin
            state_nx = ST_RD_WAIT;
            cnt_nx   = DELAY_W'(READ_DELAY);
          end
        end
      end
      ST_RD_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= DELAY_W'(1)) state_nx = ST_RD_ACK;
      end
      ST_WR_ACK: begin
        ack      = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_RD_ACK: begin
        ack      = 1'b1;
        rd_data  = cap_rd;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_cfg_responder.sv
// ----------------------------------------------------------------------------
// tb_sw_cfg_responder : scoreboard bench, three instances (READ_DELAY 1, 3, 0)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sw_cfg_responder;

  localparam int         NREG = 8;
  localparam int         RD_A = 1;
  localparam int         RD_B = 3;
  localparam int         RD_C = 0;
  localparam logic [7:0] RV_A = 8'h3C;
  localparam logic [7:0] RV_B = 8'h5A;
  localparam logic [7:0] RV_C = 8'h00;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         exp_cyc;
  } item_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } clog_t;

  logic clk = 1'b0;
  logic rst, b_rst;
  always #5 clk = ~clk;

  logic        a_sel, a_wr, a_ack, a_busy, a_proto;
  logic [7:0]  a_addr, a_wdata, a_rd;
  logic [63:0] a_cfg;
  logic        b_sel, b_wr, b_ack, b_busy, b_proto;
  logic [7:0]  b_addr, b_wdata, b_rd;
  logic [63:0] b_cfg;
  logic        c_sel, c_wr, c_ack, c_busy, c_proto;
  logic [7:0]  c_addr, c_wdata, c_rd;
  logic [63:0] c_cfg;

  sw_cfg_responder #(.READ_DELAY(RD_A), .W_WIDTH(8), .NUM_REGS(NREG), .RESET_VAL(RV_A)) u_a (
    .clk(clk), .rst(rst), .sel_en(a_sel), .wr_rd_s(a_wr), .addr(a_addr), .wr_data(a_wdata),
    .ack(a_ack), .rd_data(a_rd), .busy(a_busy), .cfg_out(a_cfg), .proto_err(a_proto));

  sw_cfg_responder #(.READ_DELAY(RD_B), .W_WIDTH(8), .NUM_REGS(NREG), .RESET_VAL(RV_B)) u_b (
    .clk(clk), .rst(b_rst), .sel_en(b_sel), .wr_rd_s(b_wr), .addr(b_addr), .wr_data(b_wdata),
    .ack(b_ack), .rd_data(b_rd), .busy(b_busy), .cfg_out(b_cfg), .proto_err(b_proto));

  sw_cfg_responder #(.READ_DELAY(RD_C), .W_WIDTH(8), .NUM_REGS(NREG), .RESET_VAL(RV_C)) u_c (
    .clk(clk), .rst(rst), .sel_en(c_sel), .wr_rd_s(c_wr), .addr(c_addr), .wr_data(c_wdata),
    .ack(c_ack), .rd_data(c_rd), .busy(c_busy), .cfg_out(c_cfg), .proto_err(c_proto));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit proto_expect = 1'b0;
  int proto_from = 0;
  int b_ack_cnt = 0;

  item_t      q[$];
  clog_t      c_log[$];
  logic [7:0] model_regs [NREG];
  logic [7:0] exp_cfg    [NREG];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for instance A: every cycle checks cfg bus, proto_err, ack/rd_data.
  always @(negedge clk) begin : mon_a
    item_t       it;
    logic [63:0] flat;
    if (mon_en) begin
      for (int i = 0; i < NREG; i++) flat[i*8 +: 8] = exp_cfg[i];
      chk("a_cfg_out", a_cfg, flat);
      chk("a_proto_err", {63'd0, a_proto}, {63'd0, (proto_expect && (cyc >= proto_from))});
      if (a_ack === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_ack: got ack=1 expected no ack (cycle %0d)", cyc);
        end else begin
          it = q.pop_front();
          chk("a_ack_cycle", 64'(cyc), 64'(it.exp_cyc));
          chk("a_rd_data_ack", {56'd0, a_rd}, {56'd0, it.rdata});
          if (it.is_wr && (it.addr < NREG)) exp_cfg[it.addr[2:0]] = it.wdata;
        end
      end else begin
        chk("a_rd_data_idle", {56'd0, a_rd}, 64'd0);
        if (q.size() != 0 && q[0].exp_cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL a_missing_ack: got none expected ack at cycle %0d (now %0d)", q[0].exp_cyc, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_ack === 1'b1) b_ack_cnt++;
    if (mon_en) begin
      if (c_ack === 1'b1) c_log.push_back('{cyc: cyc, d: c_rd});
      else chk("c_rd_data_idle", {56'd0, c_rd}, 64'd0);
    end
  end

  task automatic a_issue(input bit wr, input logic [7:0] ad, input logic [7:0] dt);
    item_t it;
    int    guard;
    guard = 0;
    @(posedge clk); #1;
    while (a_busy) begin
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL a_busy_timeout: got busy=1 expected idle within 40 cycles");
        return;
      end
      @(posedge clk); #1;
    end
    a_sel = 1'b1; a_wr = wr; a_addr = ad; a_wdata = dt;
    it.is_wr   = wr;
    it.addr    = ad;
    it.wdata   = dt;
    it.rdata   = (!wr && ad < NREG) ? model_regs[ad[2:0]] : 8'h00;
    it.exp_cyc = cyc + 1 + (wr ? 0 : RD_A);
    if (wr && ad < NREG) model_regs[ad[2:0]] = dt;
    q.push_back(it);
    @(posedge clk); #1;
    a_sel = 1'b0;
  endtask

  task automatic c_req(input bit wr, input logic [7:0] ad, input logic [7:0] dt);
    @(posedge clk); #1;
    c_sel = 1'b1; c_wr = wr; c_addr = ad; c_wdata = dt;
    @(posedge clk); #1;
    c_sel = 1'b0;
  endtask

  task automatic drain_a();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    chk("a_queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int t1;
    int e;
    int snap;
    bit got;
    logic [7:0] ad;
    item_t it;

    for (int i = 0; i < NREG; i++) begin
      model_regs[i] = RV_A;
      exp_cfg[i]    = RV_A;
    end
    rst = 1'b1; b_rst = 1'b1;
    a_sel = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_sel = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    c_sel = 0; c_wr = 0; c_addr = 0; c_wdata = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    chk("rst_a_ack", {63'd0, a_ack}, 64'd0);
    chk("rst_a_rd_data", {56'd0, a_rd}, 64'd0);
    chk("rst_a_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_a_proto", {63'd0, a_proto}, 64'd0);
    chk("rst_a_cfg", a_cfg, {8{RV_A}});
    chk("rst_b_cfg", b_cfg, {8{RV_B}});
    chk("rst_c_cfg", c_cfg, {8{RV_C}});
    mon_en = 1'b1;

    // Directed: write/read addr 3, unmapped write/read at 0x20.
    a_issue(1'b1, 8'd3, 8'hA5);
    a_issue(1'b0, 8'd3, 8'h00);
    a_issue(1'b1, 8'h20, 8'hFF);
    a_issue(1'b0, 8'h20, 8'h00);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        8:       ad = 8'd8;
        9:       ad = 8'($urandom_range(9, 255));
        default: ad = 8'($urandom_range(0, NREG - 1));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      a_issue(1'($urandom_range(0, 1)), ad, 8'($urandom));
    end
    drain_a();

    // Protocol violation: sel_en held high from accept through the end of the ack cycle.
    @(posedge clk); #1;
    a_sel = 1'b1; a_wr = 1'b0; a_addr = 8'd3; a_wdata = 8'h00;
    it.is_wr = 1'b0; it.addr = 8'd3; it.wdata = 8'h00;
    it.rdata = model_regs[3]; it.exp_cyc = cyc + 1 + RD_A;
    q.push_back(it);
    proto_from   = cyc + 2;
    proto_expect = 1'b1;
    @(posedge clk); #1;
    a_wr = 1'b1; a_wdata = ~model_regs[3];
    repeat (RD_A + 1) @(posedge clk);
    #1; a_sel = 1'b0;
    repeat (6) @(posedge clk);
    drain_a();

    // Instance B: reset during RD_WAIT, then read back the reset value.
    @(posedge clk); #1;
    b_sel = 1'b1; b_wr = 1'b1; b_addr = 8'd0; b_wdata = 8'h11;
    @(posedge clk); #1; b_sel = 1'b0;
    @(negedge clk); chk("b_wr_ack", {63'd0, b_ack}, 64'd1);
    @(negedge clk); chk("b_cfg0_written", {56'd0, b_cfg[7:0]}, 64'h11);
    @(posedge clk); #1;
    b_sel = 1'b1; b_wr = 1'b0; b_addr = 8'd0;
    @(posedge clk); #1; b_sel = 1'b0;
    snap = b_ack_cnt;
    @(posedge clk); #1; b_rst = 1'b1;
    @(posedge clk); #1; b_rst = 1'b0;
    @(negedge clk);
    chk("b_busy_after_rst", {63'd0, b_busy}, 64'd0);
    chk("b_cfg_after_rst", b_cfg, {8{RV_B}});
    repeat (8) @(negedge clk);
    chk("b_no_ack_after_rst", 64'(b_ack_cnt), 64'(snap));
    @(posedge clk); #1;
    b_sel = 1'b1; b_wr = 1'b0; b_addr = 8'd0;
    @(posedge clk); #1; b_sel = 1'b0;
    e = cyc;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (b_ack === 1'b1) begin
        got = 1'b1;
        chk("b_rd_ack_cycle", 64'(cyc), 64'(e + RD_B));
        chk("b_rd_reset_val", {56'd0, b_rd}, {56'd0, RV_B});
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL b_rd_ack_timeout: got no ack expected ack within 10 cycles");
    end

    // Instance C (READ_DELAY 0): back-to-back reads at the earliest legal cycles.
    c_req(1'b1, 8'd1, 8'h71);
    c_req(1'b1, 8'd2, 8'h82);
    repeat (2) @(posedge clk);
    #1; c_log.delete();
    c_req(1'b0, 8'd1, 8'h00);
    t1 = cyc;
    c_req(1'b0, 8'd2, 8'h00);
    repeat (3) @(negedge clk);
    chk("c_ack_count", 64'(c_log.size()), 64'd2);
    if (c_log.size() == 2) begin
      chk("c_ack1_cycle", 64'(c_log[0].cyc), 64'(t1));
      chk("c_ack1_data", {56'd0, c_log[0].d}, 64'h71);
      chk("c_ack2_cycle", 64'(c_log[1].cyc), 64'(t1 + 2));
      chk("c_ack2_data", {56'd0, c_log[1].d}, 64'h82);
    end
    chk("c_proto_err", {63'd0, c_proto}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
